// File: rtl/mem_responder.sv
// Word-addressed unified memory with a request/ready handshake and a configurable number of wait states.
// Misaligned or out-of-range accesses are rejected and flagged with MemErr alongside MemReady.
module mem_responder #(
    parameter int WORDS = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, wdata_q, rdata_q;
    logic        we_q, err_q;

    logic             enter_resp;
    logic [31:0]      acc_adr, acc_wdata;
    logic             acc_we, acc_err;
    logic [IDX_W-1:0] acc_idx;

    logic [31:0] mem_q [WORDS];

    // With WAIT=0 the commit happens on the acceptance edge itself, so the live inputs are used there.
    assign acc_adr   = (state_q == IDLE) ? Adr       : adr_q;
    assign acc_we    = (state_q == IDLE) ? MemWrite  : we_q;
    assign acc_wdata = (state_q == IDLE) ? WriteData : wdata_q;
    assign acc_idx   = acc_adr[IDX_W+1:2];
    assign acc_err   = (acc_adr[1:0] != 2'b00) || ({2'b00, acc_adr[31:2]} >= 32'(WORDS));

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemReq) begin
                    if (WAIT == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && MemReq) begin
                adr_q   <= Adr;
                wdata_q <= WriteData;
                we_q    <= MemWrite;
            end
            if (enter_resp) begin
                err_q <= acc_err;
                if (acc_err) begin
                    rdata_q <= 32'd0;
                end else if (!acc_we) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    // NOTE: the array has no reset; an aborted write never reaches it because commits only happen entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && !acc_err) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign MemReady = (state_q == RESP);
    assign MemErr   = MemReady && err_q;
    assign ReadData = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT=2 instance for handshake/error/reset cases,
// and a WAIT=0 instance for back-to-back requests.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req, mwrite;
    logic [31:0] adr, wdata, rdata;
    logic        ready, merr;

    logic        req0, mwrite0;
    logic [31:0] adr0, wdata0, rdata0;
    logic        ready0, merr0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(.WORDS(64), .WAIT(2)) dut (
        .clk(clk), .reset(reset), .MemReq(req), .MemWrite(mwrite), .Adr(adr),
        .WriteData(wdata), .ReadData(rdata), .MemReady(ready), .MemErr(merr)
    );

    mem_responder #(.WORDS(64), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .MemReq(req0), .MemWrite(mwrite0), .Adr(adr0),
        .WriteData(wdata0), .ReadData(rdata0), .MemReady(ready0), .MemErr(merr0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT=2 instance; lat is the cycle after acceptance in which MemReady was seen (0 = none).
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd, input bit tamper,
                          output logic [31:0] rd, output logic err, output int lat);
        @(posedge clk);
        @(negedge clk);
        req = 1'b1; mwrite = we; adr = a; wdata = wd;
        @(posedge clk); #1;
        if (tamper) begin
            adr = 32'h20; mwrite = 1'b1; wdata = 32'h9999_9999;
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (ready) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        rd  = rdata;
        err = merr;
        req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          seen;

        reset = 1'b0;
        req = 1'b0; mwrite = 1'b0; adr = '0; wdata = '0;
        req0 = 1'b0; mwrite0 = 1'b0; adr0 = '0; wdata0 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(merr), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Write then read back, with latency of WAIT+1 cycles
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, err, lat);
        check("wr10_lat", 32'(lat), 32'd3);
        check("wr10_err", 32'(err), 32'd0);
        check("wr10_rdata_hold", rd, 32'd0);
        access(1'b0, 32'h10, 32'h0, 1'b0, rd, err, lat);
        check("rd10_lat", 32'(lat), 32'd3);
        check("rd10_data", rd, 32'hDEAD_BEEF);
        check("rd10_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        check("between_ready", 32'(ready), 32'd0);
        check("between_err", 32'(merr), 32'd0);
        check("between_rdata", rdata, 32'hDEAD_BEEF);

        // Misaligned accesses
        access(1'b0, 32'h13, 32'h0, 1'b0, rd, err, lat);
        check("rd13_err", 32'(err), 32'd1);
        check("rd13_data", rd, 32'd0);
        access(1'b1, 32'h12, 32'h1234_5678, 1'b0, rd, err, lat);
        check("wr12_err", 32'(err), 32'd1);
        access(1'b0, 32'h10, 32'h0, 1'b0, rd, err, lat);
        check("rd10_after_mis", rd, 32'hDEAD_BEEF);

        // Range boundary: index 63 valid, index 64 and high bits rejected without aliasing onto word 0
        access(1'b1, 32'h0, 32'h5555_5555, 1'b0, rd, err, lat);
        check("wr0_err", 32'(err), 32'd0);
        access(1'b1, 32'hFC, 32'hA5A5_A5A5, 1'b0, rd, err, lat);
        check("wrFC_err", 32'(err), 32'd0);
        access(1'b0, 32'hFC, 32'h0, 1'b0, rd, err, lat);
        check("rdFC_data", rd, 32'hA5A5_A5A5);
        check("rdFC_err", 32'(err), 32'd0);
        access(1'b1, 32'h100, 32'h1111_1111, 1'b0, rd, err, lat);
        check("wr100_err", 32'(err), 32'd1);
        access(1'b0, 32'h100, 32'h0, 1'b0, rd, err, lat);
        check("rd100_err", 32'(err), 32'd1);
        check("rd100_data", rd, 32'd0);
        access(1'b1, 32'h8000_0000, 32'h2222_2222, 1'b0, rd, err, lat);
        check("wr8000_err", 32'(err), 32'd1);
        access(1'b0, 32'h0, 32'h0, 1'b0, rd, err, lat);
        check("rd0_no_alias", rd, 32'h5555_5555);

        // Request fields changed during BUSY are ignored
        access(1'b1, 32'h20, 32'h7777_7777, 1'b0, rd, err, lat);
        access(1'b0, 32'h10, 32'h0, 1'b1, rd, err, lat);
        check("tamper_lat", 32'(lat), 32'd3);
        check("tamper_data", rd, 32'hDEAD_BEEF);
        check("tamper_err", 32'(err), 32'd0);
        access(1'b0, 32'h20, 32'h0, 1'b0, rd, err, lat);
        check("rd20_unmod", rd, 32'h7777_7777);

        // Reset during BUSY aborts a pending write
        @(posedge clk);
        @(negedge clk);
        req = 1'b1; mwrite = 1'b1; adr = 32'h10; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_err", 32'(merr), 32'd0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        access(1'b0, 32'h10, 32'h0, 1'b0, rd, err, lat);
        check("abort_kept", rd, 32'hDEAD_BEEF);

        // WAIT=0: held request gives a response every other cycle
        @(negedge clk);
        req0 = 1'b1; mwrite0 = 1'b1; adr0 = 32'h10; wdata0 = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("w0_wr_ready", 32'(ready0), 32'd1);
        check("w0_wr_err", 32'(merr0), 32'd0);
        req0 = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b1; mwrite0 = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("w0_ready_%0d", i), 32'(ready0), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (ready0) begin
                check($sformatf("w0_data_%0d", i), rdata0, 32'hCAFE_F00D);
                check($sformatf("w0_err_%0d", i), 32'(merr0), 32'd0);
                seen++;
            end
        end
        check("w0_count", 32'(seen), 32'd5);
        req0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
